// File: rtl/shift_reg_seq_if.sv
// Command/status bundle for shift_reg_seq: the controller drives commands, the register reports status.
interface shift_reg_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] amt;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, d, amt, sin,
        input  q, sout, busy, done
    );

    modport slave (
        input  start, mode, d, amt, sin,
        output q, sout, busy, done
    );
endinterface

// File: rtl/shift_reg_seq.sv
// WIDTH-bit register with parallel load and multi-step shift/rotate,
// one bit position per clock, reporting completion with a one-cycle done pulse.
module shift_reg_seq #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      CNT_W   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic              c,
    input logic              rst,
    shift_reg_seq_if.slave   bus
);

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_ROR  = 2'b11;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic             r_sout, w_sout_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_mode, w_mode_nxt;

    // State and datapath registers
    always_ff @(posedge c or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_q     <= RST_VAL;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_mode  <= MODE_LOAD;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_sout  <= w_sout_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // Next-state and next-output logic; done is a pulse so it defaults low
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_sout_nxt  = r_sout;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.mode == MODE_LOAD) begin
                        w_q_nxt    = bus.d;
                        w_done_nxt = 1'b1;
                    end else if (bus.amt == CNT_W'(0)) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_mode_nxt  = bus.mode;
                        w_cnt_nxt   = bus.amt;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                // sin is taken live on each step edge
                case (r_mode)
                    MODE_SHL: begin
                        w_q_nxt    = {r_q[WIDTH-2:0], bus.sin};
                        w_sout_nxt = r_q[WIDTH-1];
                    end
                    MODE_SHR: begin
                        w_q_nxt    = {bus.sin, r_q[WIDTH-1:1]};
                        w_sout_nxt = r_q[0];
                    end
                    MODE_ROR: begin
                        w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
                        w_sout_nxt = r_q[0];
                    end
                    default: ;
                endcase
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.q    = r_q;
    assign bus.sout = r_sout;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq: directed scenarios followed by random
// commands, compared against an arithmetic reference model of the register.
module tb_shift_reg_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam logic [WIDTH-1:0] RST_VAL = '0;
    localparam longint MODV = 64'd1 << WIDTH;
    localparam longint TOPV = 64'd1 << (WIDTH - 1);

    logic c;
    logic rst;
    int   checks;
    int   errors;

    longint m_q;
    longint m_sout;

    shift_reg_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_reg_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RST_VAL(RST_VAL)) dut (
        .c   (c),
        .rst (rst),
        .bus (bus)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    // One step of the reference model, expressed as integer arithmetic
    task automatic model_step(input logic [1:0] mode, input logic s);
        longint sv;
        sv = longint'(s);
        case (mode)
            2'b01: begin m_sout = m_q / TOPV; m_q = (m_q * 2 + sv) % MODV; end
            2'b10: begin m_sout = m_q % 2;    m_q = m_q / 2 + sv * TOPV; end
            2'b11: begin m_sout = m_q % 2;    m_q = m_q / 2 + (m_q % 2) * TOPV; end
            default: ;
        endcase
    endtask

    task automatic chk_state(input string tag, input logic exp_busy, input logic exp_done);
        chk({tag, ".q"},    64'(bus.q),    64'(m_q));
        chk({tag, ".sout"}, 64'(bus.sout), 64'(m_sout));
        chk({tag, ".busy"}, 64'(bus.busy), 64'(exp_busy));
        chk({tag, ".done"}, 64'(bus.done), 64'(exp_done));
    endtask

    // Issue a command at the next edge and follow it to completion.
    // sin_fix < 0 randomises sin; noise 1 = random start/mode/d/amt while busy,
    // noise 2 = a LOAD 0xFF strobe on the second step.
    task automatic op(input string tag, input logic [1:0] mode, input int amt,
                      input logic [WIDTH-1:0] d, input int sin_fix,
                      input int noise, input bit idle_after);
        logic s;
        bus.start = 1'b1;
        bus.mode  = mode;
        bus.amt   = CNT_W'(amt);
        bus.d     = d;
        bus.sin   = 1'($urandom);
        tick();
        bus.start = 1'b0;
        if (mode == 2'b00 || amt == 0) begin
            if (mode == 2'b00) m_q = longint'(d);
            chk_state({tag, ".accept"}, 1'b0, 1'b1);
        end else begin
            chk_state({tag, ".accept"}, 1'b1, 1'b0);
            for (int i = 1; i <= amt; i++) begin
                s = (sin_fix < 0) ? 1'($urandom) : 1'(sin_fix);
                bus.sin = s;
                if (noise == 1) begin
                    bus.start = 1'($urandom);
                    bus.mode  = 2'($urandom);
                    bus.amt   = CNT_W'($urandom);
                    bus.d     = WIDTH'($urandom);
                end else if (noise == 2) begin
                    bus.start = (i == 2);
                    bus.mode  = 2'b00;
                    bus.d     = 8'hFF;
                end
                model_step(mode, s);
                tick();
                chk_state($sformatf("%s.step%0d", tag, i), (i < amt), (i == amt));
            end
            bus.start = 1'b0;
        end
        if (idle_after) begin
            tick();
            chk_state({tag, ".after"}, 1'b0, 1'b0);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        bus.d     = '0;
        bus.amt   = '0;
        bus.sin   = 1'b0;
        m_q       = longint'(RST_VAL);
        m_sout    = 0;

        // Reset holds with no clock dependency
        #3;
        chk_state("rst_hold", 1'b0, 1'b0);
        tick();
        tick();
        chk_state("rst_clk", 1'b0, 1'b0);
        rst = 1'b1;

        // Abandon an SHL amt=5 after two steps with an asynchronous reset
        op("load_pre", 2'b00, 0, 8'h3C, -1, 0, 1'b1);
        bus.start = 1'b1; bus.mode = 2'b01; bus.amt = 4'd5; bus.sin = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        m_q = longint'(RST_VAL);
        m_sout = 0;
        chk_state("rst_mid", 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_state($sformatf("rst_nodone%0d", i), 1'b0, 1'b0);
        end

        // LOAD then SHL amt=3 with sin=1
        op("load_a5", 2'b00, 0, 8'hA5, -1, 0, 1'b1);
        chk("load_a5.lit", 64'(bus.q), 64'h A5);
        op("shl3", 2'b01, 3, 8'h00, 1, 0, 1'b1);
        chk("shl3.lit", 64'(bus.q), 64'h2F);

        // ROR by 9 wraps to a rotate by 1; sin toggles randomly
        op("load_81", 2'b00, 0, 8'h81, -1, 0, 1'b1);
        op("ror9", 2'b11, 9, 8'h00, -1, 0, 1'b1);
        chk("ror9.lit", 64'(bus.q), 64'hC0);

        // amt=0 is a zero-latency no-op; LOAD strobe during SHR is ignored
        op("shr0", 2'b10, 0, 8'h55, -1, 0, 1'b1);
        op("shr4_ign", 2'b10, 4, 8'h00, -1, 2, 1'b1);

        // Back-to-back: second command issued in the done cycle
        op("load_f0", 2'b00, 0, 8'hF0, -1, 0, 1'b1);
        op("b2b_shr", 2'b10, 2, 8'h00, 0, 0, 1'b0);
        chk("b2b_shr.lit", 64'(bus.q), 64'h3C);
        op("b2b_shl", 2'b01, 1, 8'h00, 1, 0, 1'b1);
        chk("b2b_shl.lit", 64'(bus.q), 64'h79);

        // Random commands, with random back-to-back and bus noise while busy
        for (int n = 0; n < 60; n++) begin
            op($sformatf("rnd%0d", n), 2'($urandom), int'($urandom_range(0, 15)),
               WIDTH'($urandom), -1, int'($urandom_range(0, 1)), 1'($urandom));
        end
        tick();
        chk_state("final", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_seq.md
Name: shift_reg_seq

Overview:
Parametrised successor to the single-bit flip-flop: a WIDTH-bit register with parallel load, plus multi-step shift and rotate operations run by a small controller.
- A command (mode, amount) is accepted on a start strobe.
- The register then steps one bit position per clock until the amount is used up, and a one-cycle done pulse reports completion.
- Used as a serialiser/deserialiser and barrel-shift substitute in the datapath.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of shift-amount input and internal down-counter
RST_VAL, 0, value loaded into q on reset (WIDTH bits)

Ports:
c  input  1  clock, rising-edge active
rst  input  1  asynchronous reset, active-low
start  input  1  command strobe, sampled on rising edge of c
mode  input  2  00 LOAD, 01 SHL, 10 SHR, 11 ROR
d  input  WIDTH  parallel load data
amt  input  CNT_W  number of single-bit steps (ignored for LOAD)
sin  input  1  serial fill bit for SHL/SHR
q  output  WIDTH  register contents
sout  output  1  bit ejected on the most recent shift/rotate step
busy  output  1  high while a multi-step operation is in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0), asynchronous, no clock needed:
  - q=RST_VAL, sout=0, busy=0, done=0.
  - State IDLE, counter 0.
  - Applies even mid-operation; the operation is abandoned, with no done pulse.
- States: IDLE, SHIFT. All outputs are registered.
- IDLE with start=1 at edge k:
  - LOAD: q<=d at edge k. done=1 for the cycle after edge k. busy stays 0. Latency 1.
  - SHL/SHR/ROR with amt=0: q and sout unchanged. done=1 for the cycle after edge k. busy stays 0.
  - SHL/SHR/ROR with amt>0: latch mode, set counter=amt, go to SHIFT, busy=1 after edge k. q is not changed at edge k.
- SHIFT: on each edge, perform one step and decrement the counter.
  - SHL: q<={q[WIDTH-2:0],sin}, sout<=q[WIDTH-1].
  - SHR: q<={sin,q[WIDTH-1:1]}, sout<=q[0].
  - ROR: q<={q[0],q[WIDTH-1:1]}, sout<=q[0]. sin is ignored.
  - sin is sampled live on every step edge, not latched at start.
- Completion of a multi-step operation:
  - Steps occur at edges k+1 .. k+amt.
  - At edge k+amt (counter reaching 1): go to IDLE, busy<=0, done<=1.
  - busy is high exactly amt cycles. done is high exactly 1 cycle, after edge k+amt.
- amt may exceed WIDTH:
  - ROR wraps naturally (net effect is rotation by amt mod WIDTH).
  - SHL/SHR simply keep filling with sin.
- Start during SHIFT is ignored entirely; mode, amt and d are don't-care.
- Start in the cycle where done=1 (state already IDLE) is accepted normally: back-to-back operation with no dead cycle.
- done is cleared on the next edge unless a new zero-latency command (LOAD or amt=0) re-asserts it.
- mode, amt and d changes while busy have no effect.

Test Plan:
- Reset (WIDTH=8, RST_VAL=0): hold rst=0 -> q=0x00, busy=0, done=0, sout=0. Then start SHL amt=5 and drop rst low after 2 steps, between edges -> q=0x00, busy=0 immediately, no done pulse afterward.
- LOAD: start, mode=00, d=0xA5 -> q=0xA5 after 1 edge; done high exactly 1 cycle; busy never high.
- SHL: from q=0xA5, mode=01, amt=3, sin=1 -> q steps 0x4B, 0x97, 0x2F; sout steps 1, 0, 1; busy high 3 cycles; done 1 cycle after third step.
- ROR wrap: from q=0x81, mode=11, amt=9 -> final q=0xC0; busy high 9 cycles; sin toggling has no effect.
- Ignore/zero cases:
  - amt=0, SHR -> q unchanged, done after 1 edge, busy stays 0.
  - During an SHR amt=4, pulse start with LOAD d=0xFF -> ignored; q shows only the shift results.
- Back-to-back: from q=0xF0, SHR amt=2, sin=0 -> q=0x78 then 0x3C, sout 0, 0. Then in the done cycle, start SHL amt=1, sin=1 -> accepted; q=0x79 one edge later; second done pulse.
